// File: rtl/ltc2324_emu_pkg.sv
// Shared types and constants for the LTC2324-16 device-side emulator.
package ltc2324_emu_pkg;
  localparam int NBITS_C   = 16;
  localparam int CNT_W     = 8;
  localparam int BIT_W     = 5;
  localparam int NUM_LANES = 4;
  localparam logic [NBITS_C-1:0] PATTERN_C = 16'h5A5A;

  typedef enum logic [1:0] {IDLE, CONV, READ} state_t;
endpackage

// File: rtl/ltc_emu_lane.sv
// One SDO lane: 16-bit parallel-load, MSB-first shift register.
module ltc_emu_lane
  import ltc2324_emu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [NBITS_C-1:0] din,
  output logic               sdo
);
  logic [NBITS_C-1:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sh <= '0;
    else if (load)  sh <= din;
    else if (shift) sh <= {sh[NBITS_C-2:0], 1'b0};
  end

  assign sdo = sh[NBITS_C-1];
endmodule

// File: rtl/ltc2324_16_emu.sv
// LTC2324-16 emulator answering CNV/SCK with CLKOUT and four SDO lanes.
// Define LTC_EMU_PATTERN_EN to replace ch*_in with a per-conversion test pattern.
module ltc2324_16_emu
  import ltc2324_emu_pkg::*;
#(
  parameter int CONV_CYCLES  = 20,
  parameter int CLKOUT_DELAY = 2,
  parameter int NBITS        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CNV,
  input  logic        SCK,
  input  logic [15:0] ch1_in,
  input  logic [15:0] ch2_in,
  input  logic [15:0] ch3_in,
  input  logic [15:0] ch4_in,
  output logic        CLKOUT,
  output logic        SDO1,
  output logic        SDO2,
  output logic        SDO3,
  output logic        SDO4,
  output logic        busy,
  output logic [15:0] overrun_cnt
);
  if (NBITS != NBITS_C) begin : g_nbits_chk
    $error("ltc2324_16_emu: NBITS must be 16");
  end
  if (CONV_CYCLES < 1 || CONV_CYCLES > 255) begin : g_conv_chk
    $error("ltc2324_16_emu: CONV_CYCLES out of range 1..255");
  end

  state_t             state_q, state_d;
  logic               sck_q, cnv_q, fall, cnv_rise;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic               load, shift, ovr_inc, sdo_en;
  logic [NUM_LANES-1:0][NBITS_C-1:0] words;
  logic [NUM_LANES-1:0]              lane_sdo;

  assign fall     = sck_q & ~SCK;
  assign cnv_rise = CNV & ~cnv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sck_q   <= 1'b0;
      cnv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q   <= SCK;
      cnv_q   <= CNV;
    end
  end

  // A new CNV during readout takes priority over the final falling edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cnv_rise) state_d = CONV;
      CONV: if (cnt_q == '0 && !CNV) state_d = READ;
      READ: begin
        if (cnv_rise) state_d = CONV;
        else if (fall && bit_cnt_q == BIT_W'(NBITS_C - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = cnv_rise && (state_q != CONV);
    shift   = fall && (state_q == READ) && !cnv_rise;
    ovr_inc = cnv_rise && (state_q == CONV);
    busy    = (state_q == CONV);
    sdo_en  = (state_q == READ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      overrun_cnt <= '0;
    end else begin
      if (load)                 cnt_q <= CNT_W'(CONV_CYCLES - 1);
      else if (cnt_q != '0 && state_q == CONV) cnt_q <= cnt_q - 1'b1;
      if (state_q != READ)      bit_cnt_q <= '0;
      else if (shift)           bit_cnt_q <= bit_cnt_q + 1'b1;
      if (ovr_inc && overrun_cnt != 16'hFFFF) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

`ifdef LTC_EMU_PATTERN_EN
  logic [15:0] conv_k;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    conv_k <= '0;
    else if (load) conv_k <= conv_k + 16'd1;
  end
  assign words = {{conv_k[13:0], 2'b00}, PATTERN_C, ~conv_k, conv_k};
`else
  assign words = {ch4_in, ch3_in, ch2_in, ch1_in};
`endif

  ltc_emu_lane u_lane [NUM_LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (words),
    .sdo   (lane_sdo)
  );

  assign {SDO4, SDO3, SDO2, SDO1} = lane_sdo & {NUM_LANES{sdo_en}};

  if (CLKOUT_DELAY == 0) begin : g_nodly
    assign CLKOUT = SCK;
  end else begin : g_dly
    logic [CLKOUT_DELAY-1:0] dly;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly <= '0;
      else begin
        dly[0] <= SCK;
        for (int i = 1; i < CLKOUT_DELAY; i++) dly[i] <= dly[i-1];
      end
    end
    assign CLKOUT = dly[CLKOUT_DELAY-1];
  end
endmodule

// File: tb/tb_ltc2324_16_emu.sv
// Directed-sequence bench with randomized channel data for ltc2324_16_emu.
module tb_ltc2324_16_emu;
  localparam int CONV_CYCLES = 20;

  logic        clk = 1'b0;
  logic        rst_n, CNV, SCK;
  logic [15:0] ch1_in, ch2_in, ch3_in, ch4_in;
  logic        CLKOUT, SDO1, SDO2, SDO3, SDO4, busy;
  logic [15:0] overrun_cnt;
  logic [3:0]  sdo_v;

  int          n_pass = 0;
  int          n_checks = 0;
  int          busy_n = 0;
  logic [15:0] conv_k = '0;
  logic [15:0] ovr_exp = '0;
  logic [3:0][15:0] exp_w, cap;

  always #5 clk = ~clk;

  ltc2324_16_emu dut (
    .clk(clk), .rst_n(rst_n), .CNV(CNV), .SCK(SCK),
    .ch1_in(ch1_in), .ch2_in(ch2_in), .ch3_in(ch3_in), .ch4_in(ch4_in),
    .CLKOUT(CLKOUT), .SDO1(SDO1), .SDO2(SDO2), .SDO3(SDO3), .SDO4(SDO4),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  assign sdo_v = {SDO4, SDO3, SDO2, SDO1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(negedge clk);
    if (busy === 1'b1) busy_n++;
  endtask

  // Words the converter should capture at the next accepted conversion start.
  function automatic logic [3:0][15:0] words_now();
`ifdef LTC_EMU_PATTERN_EN
    logic [15:0] k4;
    k4 = conv_k * 16'd4;
    return {k4, 16'h5A5A, ~conv_k, conv_k};
`else
    return {ch4_in, ch3_in, ch2_in, ch1_in};
`endif
  endfunction

  task automatic rand_ch();
    ch1_in = 16'($urandom); ch2_in = 16'($urandom);
    ch3_in = 16'($urandom); ch4_in = 16'($urandom);
  endtask

  task automatic start_cnv();
    exp_w  = words_now();
    conv_k = conv_k + 16'd1;
    busy_n = 0;
    CNV = 1'b1;
    tick();
    CNV = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic wait_conv();
    tick();
    check("sdo_in_conv", 64'(sdo_v), 64'd0);
    for (int t = 0; t < 300 && busy === 1'b1; t++) tick();
    check("conv_timeout", 64'(busy), 64'd0);
    check("busy_len", 64'(busy_n), 64'(CONV_CYCLES));
    check("first_bit", 64'(sdo_v),
          64'({exp_w[3][15], exp_w[2][15], exp_w[1][15], exp_w[0][15]}));
  endtask

  // Controller-side capture: sample SDO at each SCK rising edge, 4 clk per bit.
  task automatic sck_bits(input int n);
    for (int b = 0; b < n; b++) begin
      for (int l = 0; l < 4; l++) cap[l] = {cap[l][14:0], sdo_v[l]};
      SCK = 1'b1; tick(); tick();
      SCK = 1'b0; tick(); tick();
    end
  endtask

  task automatic read_check();
    cap = '0;
    sck_bits(16);
    for (int l = 0; l < 4; l++) check($sformatf("word_ch%0d", l + 1), 64'(cap[l]), 64'(exp_w[l]));
    check("idle_after_read", 64'({busy, sdo_v}), 64'd0);
  endtask

  task automatic full_conv();
    start_cnv();
    wait_conv();
    read_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s, prev;
    rst_n = 1'b0; CNV = 1'b0; SCK = 1'b0;
    ch1_in = '0; ch2_in = '0; ch3_in = '0; ch4_in = '0;
    tick(); tick();
    check("rst_sdo", 64'(sdo_v), 64'd0);
    check("rst_clkout", 64'(CLKOUT), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Idle SCK activity: CLKOUT is SCK from two edges back, data path silent.
    prev = 1'b0;
    for (int j = 0; j < 24; j++) begin
      s = 1'($urandom_range(0, 1));
      SCK = s;
      tick();
      check("clkout_delay", 64'(CLKOUT), 64'(prev));
      check("idle_quiet", 64'({busy, sdo_v}), 64'd0);
      prev = s;
    end
    SCK = 1'b0;
    tick(); tick();

    ch1_in = 16'hA5C3; ch2_in = 16'h0001; ch3_in = 16'hFFFF; ch4_in = 16'h8000;
    full_conv();

    repeat (3) begin
      rand_ch();
      full_conv();
    end

    // Second CNV 5 cycles into CONV is an overrun; first latch is kept.
    rand_ch();
    start_cnv();
    repeat (4) tick();
    rand_ch();
    CNV = 1'b1; tick(); CNV = 1'b0;
    ovr_exp = ovr_exp + 16'd1;
    check("overrun_cnt", 64'(overrun_cnt), 64'(ovr_exp));
    wait_conv();
    read_check();

    // CNV after 8 falls aborts the readout and relatches.
    rand_ch();
    start_cnv();
    wait_conv();
    cap = '0;
    sck_bits(8);
    rand_ch();
    ch1_in = 16'h1234;
    start_cnv();
    wait_conv();
    read_check();
    check("abort_no_overrun", 64'(overrun_cnt), 64'(ovr_exp));

    // Reset in the middle of a readout.
    rand_ch();
    start_cnv();
    wait_conv();
    sck_bits(7);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 64'({sdo_v, CLKOUT, busy}), 64'd0);
    check("midrst_overrun", 64'(overrun_cnt), 64'd0);
    ovr_exp = '0;
    conv_k  = '0;
    tick();
    rst_n = 1'b1;
    tick();
    rand_ch();
    full_conv();
    rand_ch();
    full_conv();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
